// File: rtl/sine_gen_pkg.sv
// Shared types and constants for the sine phase sequencer and the quarter-wave decoder.
// Pure declarations: no latency, no flow control.
package sine_gen_pkg;

  localparam int IDX_W_DEFAULT = 7;
  localparam int IDX_MAX       = (1 << IDX_W_DEFAULT) - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    Q1_UP = 3'd1,
    Q2_DN = 3'd2,
    Q3_UP = 3'd3,
    Q4_DN = 3'd4
  } sine_state_t;

  // Quadrants where the quarter-wave index climbs towards IDX_MAX.
  function automatic logic is_rising(sine_state_t s);
    return (s == Q1_UP) || (s == Q3_UP);
  endfunction

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Control/sample bus between a sequencer user (master) and the sine phase sequencer (slave).
// Pulses are single-cycle strobes; there is no backpressure on this bus.
interface sine_phase_sequencer_if #(
  parameter int IDX_W = sine_gen_pkg::IDX_W_DEFAULT,
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div;
  logic [7:0]       n_periods;
  logic [IDX_W-1:0] idx;
  logic             sign;
  logic             sample_stb;
  logic             period_done;
  logic             busy;

  modport master (
    output start, stop, div, n_periods,
    input  idx, sign, sample_stb, period_done, busy
  );

  modport slave (
    input  start, stop, div, n_periods,
    output idx, sign, sample_stb, period_done, busy
  );
endinterface

// File: rtl/sine_tick_prescaler.sv
// Sample-rate prescaler: counts 0..div and flags tick combinationally on the terminal count.
// Tick period is div+1 cycles; clr holds the count at zero, no backpressure.
module sine_tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Walks a quarter-wave index up/down through four quadrants to drive a sine decoder.
// New idx/sign one cycle after each prescaler tick (or start); outputs are free-running, no backpressure.
module sine_phase_sequencer
  import sine_gen_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int DIV_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  sine_phase_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] IDX_TOP = {IDX_W{1'b1}};

  sine_state_t      state;
  logic [IDX_W-1:0] idx_q;
  logic             sign_q;
  logic             stb_q;
  logic             busy_q;
  logic [DIV_W-1:0] div_l;
  logic [7:0]       n_l;
  logic [7:0]       per_cnt;
  logic [7:0]       per_nxt;
  logic             stop_pend;
  logic             tick;
  logic             last_sample;
  logic             run_over;

  sine_tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .div  (div_l),
    .tick (tick)
  );

  assign per_nxt     = per_cnt + 8'd1;
  assign last_sample = (state == Q4_DN) && (idx_q == '0);
  // A stop arriving on the very last tick is treated as already pending.
  assign run_over    = stop_pend || bus.stop || ((n_l != 8'd0) && (per_nxt == n_l));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      sign_q    <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_l     <= '0;
      n_l       <= '0;
      per_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if ((state != IDLE) && bus.stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            div_l     <= bus.div;
            n_l       <= bus.n_periods;
            per_cnt   <= '0;
            stop_pend <= 1'b0;
            state     <= Q1_UP;
            idx_q     <= '0;
            sign_q    <= 1'b0;
            stb_q     <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        Q1_UP, Q3_UP: begin
          if (tick) begin
            stb_q <= 1'b1;
            if (idx_q == IDX_TOP) begin
              state <= (state == Q1_UP) ? Q2_DN : Q4_DN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        Q2_DN: begin
          if (tick) begin
            stb_q <= 1'b1;
            if (idx_q == '0) begin
              state  <= Q3_UP;
              sign_q <= 1'b1;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
        end
        Q4_DN: begin
          if (tick) begin
            if (idx_q == '0) begin
              per_cnt <= per_nxt;
              idx_q   <= '0;
              sign_q  <= 1'b0;
              if (run_over) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                stop_pend <= 1'b0;
              end else begin
                state <= Q1_UP;
                stb_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q - 1'b1;
              stb_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.idx         = idx_q;
  assign bus.sign        = sign_q;
  assign bus.sample_stb  = stb_q;
  assign bus.busy        = busy_q;
  // Decoded from flops only: high during the final cycle of each period.
  assign bus.period_done = last_sample && tick && is_rising(Q1_UP);

endmodule

// File: doc/sine_phase_sequencer.md
SINE_PHASE_SEQUENCER -- requirements
Module: sine_phase_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, default 7: width of the quarter-wave sample index fed to the sine decoder.
REQ-002 SHALL have parameter DIV_W, default 8: width of the sample-rate divider input.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: start request; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1: graceful-stop request; sampled only while busy.
REQ-007 SHALL have port div, input, DIV_W: sample period minus one, in clk cycles; latched at start.
REQ-008 SHALL have port n_periods, input, 8: number of full sine periods to emit, where 0 means continuous; latched at start.
REQ-009 SHALL have port idx, output, IDX_W: quarter-wave index that drives the decoder A input; registered.
REQ-010 SHALL have port sign, output, 1: half-wave polarity (0 = positive, 1 = negative); registered.
REQ-011 SHALL have port sample_stb, output, 1: one-cycle pulse coincident with each new idx/sign value.
REQ-012 SHALL have port period_done, output, 1: one-cycle pulse at the end of each full period.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, Q1_UP, Q2_DN, Q3_UP and Q4_DN.
REQ-015 SHALL contain a prescaler that counts 0..div_l (the latched div) and asserts an internal tick when the count equals div_l; div = 0 SHALL give a tick every cycle.
REQ-016 SHALL, in IDLE on start = 1, latch div and n_periods, clear the prescaler and the period counter, enter Q1_UP with idx = 0 and sign = 0, and pulse sample_stb.
REQ-017 SHALL, on a tick in Q1_UP and Q3_UP, increment idx; when idx = 2^IDX_W-1 it SHALL instead move to the next state with idx unchanged.
REQ-018 SHALL, on a tick in Q2_DN and Q4_DN, decrement idx; when idx = 0 it SHALL instead leave the state.
REQ-019 SHALL move from Q2_DN to Q3_UP with idx = 0 and sign = 1.
REQ-020 SHALL, on leaving Q4_DN, pulse period_done and increment the period counter; it SHALL go to IDLE if the stop is pending or the count equals a non-zero n_periods, otherwise to Q1_UP with idx = 0 and sign = 0.
REQ-021 SHALL give each quadrant exactly 2^IDX_W samples, each held div_l+1 cycles, so a period is 4·2^IDX_W·(div_l+1) cycles (512·(div+1) at default width).
REQ-022 SHALL pulse sample_stb on every idx/sign update, including quadrant transitions and the entry into Q1_UP.
REQ-023 SHALL, on entering IDLE, set idx = 0 and sign = 0, deassert busy, and not pulse sample_stb.
REQ-024 SHALL set the stop-pending flag when stop = 1 while busy; it SHALL be honoured only at the end of a period, never mid-period, and cleared on entering IDLE.
REQ-025 SHALL ignore stop in IDLE; simultaneous start and stop in IDLE SHALL start the sequence with no stop pending.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL ignore changes to div and n_periods while busy.

Reset
REQ-028 SHALL, on rst = 1 and regardless of clk, force IDLE with idx = 0, sign = 0, sample_stb = 0, period_done = 0 and busy = 0, and clear the prescaler, period counter and stop-pending flag.
REQ-029 SHALL, on reset assertion mid-period, drive outputs to their reset values immediately, and SHALL not emit any pulse on release.

Structure
REQ-030 SHALL take the FSM state enum, IDX_W default and IDX_MAX constant from the shared package sine_gen_pkg, which the decoder side also uses.
REQ-031 SHALL implement the prescaler as the sub-module sine_tick_prescaler (ports: clk, rst, clr, div, tick).

Verification
REQ-032 SHALL cover: div = 0, n_periods = 1, start -> idx ramps 0..127, 127..0 (sign 0), then 0..127, 127..0 (sign 1); period_done on cycle 512; busy low on cycle 513.
REQ-033 SHALL cover: div = 3, n_periods = 2 -> each idx held 4 cycles; period_done at cycles 2048 and 4096; then IDLE.
REQ-034 SHALL cover: n_periods = 0, stop asserted mid-Q2_DN -> sequence completes Q3_UP/Q4_DN, one period_done, then IDLE with idx = 0 and sign = 0.
REQ-035 SHALL cover: rst pulsed during Q3_UP (idx = 40, sign = 1) -> idx = 0, sign = 0, busy = 0 immediately; no pulses after release.
REQ-036 SHALL cover: start re-asserted and div changed while busy -> no restart; the original period length is preserved.
REQ-037 SHALL cover: start and stop asserted together in IDLE -> run starts and completes n_periods = 1 normally.
